mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller that owns the single byte-wide RAM/IO port and shares it between the instruction fetcher and the load/store buffer. It serialises each word/half/byte request into consecutive byte accesses, assembles or disassembles the data, and returns a one-cycle done pulse to the requester. It also arbitrates fairly between the two requesters, aborts instruction fetches on pipeline flush, and stalls IO writes while the IO buffer is full.

## Interface
- No parameters. Widths come from the shared defines: `DATA_WIDTH` is 32 bits and `ADDR_WIDTH` is 32 bits.
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `rdy` input 1: global enable. When low, the block freezes.
- `in_flush` input 1: mispredict flush. Aborts an instruction fetch.
- `in_if_req` input 1: fetcher request. Held high until `out_if_done`.
- `in_if_pc` input 32: fetch address. Must be stable while `in_if_req` is high.
- `out_if_done` output 1: one-cycle pulse; `out_if_instr` is valid in the same cycle.
- `out_if_instr` output 32: fetched word, little-endian.
- `in_lsb_req` input 1: data request. Held high until `out_lsb_done`.
- `in_lsb_wr` input 1: 1 = store, 0 = load.
- `in_lsb_size` input 2: 0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes.
- `in_lsb_addr` input 32: data address.
- `in_lsb_wdata` input 32: store data. Only the low `size` bytes are used.
- `out_lsb_done` output 1: one-cycle pulse.
- `out_lsb_rdata` output 32: load data, zero-extended. Sign extension is done downstream.
- `mem_din` input 8: RAM read byte. Valid the cycle after its address is presented.
- `mem_dout` output 8: write byte.
- `mem_a` output 32: byte address.
- `mem_wr` output 1: 1 = write.
- `io_buffer_full` input 1: the IO sink cannot accept a byte.

## Operation
- States:
  - IDLE: sampling requests.
  - READ: issuing addresses and collecting bytes.
  - WRITE: issuing address and byte pairs.
  - DONE: one cycle, requests ignored.
- Reset values (asynchronous):
  - state = IDLE.
  - All outputs = 0, including `mem_wr` = 0.
  - `last_grant` = data, so that the instruction port wins the first tie.
- Arbitration in IDLE:
  - If only one request is high, grant it.
  - If both are high, grant the port opposite to `last_grant`, then update `last_grant`.
  - A grant latches address, size, write data and the requester's identity.
- Byte count n: 4 for fetches; 1, 2 or 4 for data requests.
- READ:
  - Drive `mem_a` = base+i with `mem_wr` = 0 for i = 0..n-1.
  - Capture the byte returned in the following cycle into bits [8i+7:8i].
  - After the last byte is captured, go to DONE.
- WRITE:
  - Drive `mem_a` = base+i, `mem_dout` = byte i, `mem_wr` = 1 for i = 0..n-1.
  - After the last byte is written, go to DONE.
- DONE: pulse the granted port's done output for one cycle, then go to IDLE.
  - The data output holds its value until the next grant to that port.
- Flush:
  - If `in_flush` is high while an instruction fetch is in flight (READ, or DONE for an instruction fetch), the fetch is abandoned.
  - The next state is IDLE, `out_if_done` is not pulsed, and `mem_wr` = 0.
  - Data operations ignore `in_flush`.
  - `in_flush` in IDLE blocks an instruction grant in that cycle.
- IO stall:
  - Applies while in WRITE, when the current address has [17:16] == 2'b11 and `io_buffer_full` = 1.
  - `mem_wr` is driven 0, the byte index holds, and the write resumes when `io_buffer_full` falls.
- `rdy` low: all state, counters and outputs hold, except `mem_wr`, which is forced to 0.
- Address arithmetic is a 32-bit wrap. 0xFFFF_FFFF+1 = 0.

## Timing
- A request is high in cycle C0 and sampled at the edge that starts C1.
- First address appears in C1.
- Read: bytes arrive on `mem_din` in C2..C(n+1); done is high in C(n+2).
  - A fetch therefore completes in C6.
- Write: bytes are issued in C1..Cn; done is high in C(n+1).
- IO-stall cycles and `rdy`-low cycles add 1:1 to these latencies.
- The cycle after DONE is IDLE, which samples requests at the end of that cycle.
- A requester deasserts its request on the edge after it sees done. No re-grant of a stale request occurs.
- Back-to-back throughput: n+3 cycles per read, n+2 per write.

## Structure
- Shared package/defines hold:
  - `DATA_WIDTH`, `ADDR_WIDTH`, TRUE/FALSE, the zero constant.
  - Size encodings.
  - State encodings IDLE/READ/WRITE/DONE.
  - The IO address-range constant.
- No sub-module: a single sequential process plus a small combinational arbiter.

## Test plan
- Fetch at pc 0x0000_0010 with RAM bytes 13 05 00 00:
  - `out_if_done` is high in C6 with `out_if_instr` = 0x0000_0513.
  - `mem_a` steps 0x10..0x13 over C1..C4.
- Store word 0xDEADBEEF to 0x100:
  - `mem_wr` is high in C1..C4 with bytes EF BE AD DE at 0x100..0x103.
  - `out_lsb_done` is high in C5.
- Fetch and load-byte requested together in the same cycle after reset:
  - The fetch is granted first; the load is granted on the first IDLE after the fetch's DONE.
  - A repeat collision grants the data port.
- Flush in C3 of a fetch:
  - No `out_if_done` is pulsed; the block is in IDLE in C4.
  - A pending store sampled at the end of C4 is then issued normally.
- Store byte 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles:
  - `mem_wr` stays 0 for those cycles, then is high for one cycle.
  - Done arrives 3 cycles later than it would without the stall.
- Assert `rst` mid-read (in READ):
  - Outputs go to 0 immediately, state is IDLE, and no done pulse is produced.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared widths, encodings and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic [DATA_WIDTH-1:0] ZERO = '0;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Address bits [17:16] of an IO-mapped byte.
    localparam logic [1:0] IO_RANGE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_LSB = 1'b1
    } grant_e;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// Fetcher, load/store buffer and byte-wide RAM/IO port bundled as one interface.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                  in_flush;
    logic                  in_if_req;
    logic [ADDR_WIDTH-1:0] in_if_pc;
    logic                  out_if_done;
    logic [DATA_WIDTH-1:0] out_if_instr;

    logic                  in_lsb_req;
    logic                  in_lsb_wr;
    logic [1:0]            in_lsb_size;
    logic [ADDR_WIDTH-1:0] in_lsb_addr;
    logic [DATA_WIDTH-1:0] in_lsb_wdata;
    logic                  out_lsb_done;
    logic [DATA_WIDTH-1:0] out_lsb_rdata;

    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;
    logic                  io_buffer_full;

    modport master (
        output in_flush, in_if_req, in_if_pc,
        input  out_if_done, out_if_instr,
        output in_lsb_req, in_lsb_wr, in_lsb_size, in_lsb_addr, in_lsb_wdata,
        input  out_lsb_done, out_lsb_rdata,
        output mem_din, io_buffer_full,
        input  mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  in_flush, in_if_req, in_if_pc,
        output out_if_done, out_if_instr,
        input  in_lsb_req, in_lsb_wr, in_lsb_size, in_lsb_addr, in_lsb_wdata,
        output out_lsb_done, out_lsb_rdata,
        input  mem_din, io_buffer_full,
        output mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM/IO port between the instruction fetcher and the
// load/store buffer, serialising word/half/byte requests into byte accesses.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);
    state_e                state_q, state_d;
    grant_e                owner_q, owner_d;
    grant_e                last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  if_done_q, if_done_d;
    logic                  lsb_done_q, lsb_done_d;
    logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
    logic [DATA_WIDTH-1:0] lsb_rdata_q, lsb_rdata_d;

    logic       if_req_eff, grant_if, grant_lsb, grant_wr;
    logic       io_stall, if_flush;
    logic [2:0] nxt;

    // A flush in IDLE masks the fetcher, so it never counts towards a tie.
    always_comb begin
        if_req_eff = bus.in_if_req & ~bus.in_flush;
        grant_if   = FALSE;
        grant_lsb  = FALSE;
        if (if_req_eff && bus.in_lsb_req) begin
            grant_if  = (last_grant_q == GRANT_LSB);
            grant_lsb = ~grant_if;
        end else begin
            grant_if  = if_req_eff;
            grant_lsb = bus.in_lsb_req;
        end
    end

    assign io_stall = (state_q == WRITE) && (mem_a_q[17:16] == IO_RANGE) && bus.io_buffer_full;
    assign if_flush = bus.in_flush && (owner_q == GRANT_IF) && (state_q == READ || state_q == DONE);
    assign nxt      = cnt_q + 3'd1;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        nbytes_d     = nbytes_q;
        cnt_d        = cnt_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = mem_wr_q;
        if_done_d    = if_done_q;
        lsb_done_d   = lsb_done_q;
        if_instr_d   = if_instr_q;
        lsb_rdata_d  = lsb_rdata_q;
        grant_wr     = grant_lsb & bus.in_lsb_wr;

        if (rdy) begin
            if_done_d  = FALSE;
            lsb_done_d = FALSE;
            case (state_q)
                IDLE: begin
                    if (grant_if || grant_lsb) begin
                        owner_d = grant_if ? GRANT_IF : GRANT_LSB;
                        if (if_req_eff && bus.in_lsb_req) begin
                            last_grant_d = owner_d;
                        end
                        base_d     = grant_if ? bus.in_if_pc : bus.in_lsb_addr;
                        nbytes_d   = grant_if ? 3'd4 : byte_count(bus.in_lsb_size);
                        wdata_d    = bus.in_lsb_wdata;
                        rbuf_d     = ZERO;
                        cnt_d      = 3'd0;
                        mem_a_d    = base_d;
                        mem_wr_d   = grant_wr;
                        mem_dout_d = grant_wr ? bus.in_lsb_wdata[7:0] : mem_dout_q;
                        state_d    = grant_wr ? WRITE : READ;
                    end
                end
                // cnt_q counts issued addresses; byte cnt_q-1 is on mem_din now.
                READ: begin
                    mem_wr_d = FALSE;
                    if (if_flush) begin
                        state_d = IDLE;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            rbuf_d = rbuf_q | (DATA_WIDTH'(bus.mem_din) << {cnt_q - 3'd1, 3'b000});
                        end
                        if (cnt_q == nbytes_q) begin
                            state_d = DONE;
                            if (owner_q == GRANT_IF) begin
                                if_done_d  = TRUE;
                                if_instr_d = rbuf_d;
                            end else begin
                                lsb_done_d  = TRUE;
                                lsb_rdata_d = rbuf_d;
                            end
                        end else begin
                            cnt_d = nxt;
                            if (nxt < nbytes_q) begin
                                mem_a_d = base_q + ADDR_WIDTH'(nxt);
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!io_stall) begin
                        if (nxt == nbytes_q) begin
                            state_d    = DONE;
                            mem_wr_d   = FALSE;
                            lsb_done_d = TRUE;
                        end else begin
                            cnt_d      = nxt;
                            mem_a_d    = base_q + ADDR_WIDTH'(nxt);
                            mem_dout_d = 8'(wdata_q >> {nxt, 3'b000});
                        end
                    end
                end
                DONE: begin
                    state_d  = IDLE;
                    mem_wr_d = FALSE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= GRANT_IF;
            last_grant_q <= GRANT_LSB;
            base_q       <= ZERO;
            wdata_q      <= ZERO;
            rbuf_q       <= ZERO;
            nbytes_q     <= 3'd0;
            cnt_q        <= 3'd0;
            mem_a_q      <= ZERO;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= FALSE;
            if_done_q    <= FALSE;
            lsb_done_q   <= FALSE;
            if_instr_q   <= ZERO;
            lsb_rdata_q  <= ZERO;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            nbytes_q     <= nbytes_d;
            cnt_q        <= cnt_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            if_done_q    <= if_done_d;
            lsb_done_q   <= lsb_done_d;
            if_instr_q   <= if_instr_d;
            lsb_rdata_q  <= lsb_rdata_d;
        end
    end

    // Stalls and a frozen block must never strobe a write.
    assign bus.mem_wr        = mem_wr_q & rdy & ~io_stall;
    assign bus.mem_a         = mem_a_q;
    assign bus.mem_dout      = mem_dout_q;
    assign bus.out_if_done   = if_done_q & ~bus.in_flush;
    assign bus.out_if_instr  = if_instr_q;
    assign bus.out_lsb_done  = lsb_done_q;
    assign bus.out_lsb_rdata = lsb_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, write/done scoreboard, vector table and
// hand-written arbitration, flush, IO-stall and reset sequences.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   if_done_cnt = 0;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } lexp_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gap;
        int          lat;
    } vec_t;

    wr_t         wr_q[$];
    logic [31:0] if_exp_q[$];
    lexp_t       lsb_exp_q[$];
    logic [7:0]  ram[logic [31:0]];
    vec_t        vecs[12];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0];
    endfunction

    // Byte-wide RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
        bus.mem_din <= ram_rd(bus.mem_a);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_wr) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%02h, none expected", bus.mem_a, bus.mem_dout);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write addr", bus.mem_a, w.a);
                    check("write data", 32'(bus.mem_dout), 32'(w.d));
                end
            end
            if (bus.out_if_done) begin
                if_done_cnt++;
                if (if_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_if_done: instr 0x%08h, no done expected", bus.out_if_instr);
                end else begin
                    check("if instr", bus.out_if_instr, if_exp_q.pop_front());
                end
            end
            if (bus.out_lsb_done) begin
                if (lsb_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_lsb_done: rdata 0x%08h, no done expected", bus.out_lsb_rdata);
                end else begin
                    lexp_t e;
                    e = lsb_exp_q.pop_front();
                    if (e.chk) check("lsb rdata", bus.out_lsb_rdata, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit is_if, input int c0, input int exp_lat, input string name);
        bit seen;
        int got;
        seen = 1'b0;
        got  = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (is_if ? bus.out_if_done : bus.out_lsb_done) begin
                seen = 1'b1;
                got  = cyc - c0;
            end
        end
        check({name, " latency"}, 32'(got), 32'(exp_lat));
    endtask

    task automatic run_if(input logic [31:0] pc, input logic [31:0] exp, input int exp_lat, input string name);
        int c0;
        c0 = cyc;
        bus.in_if_req = 1'b1;
        bus.in_if_pc  = pc;
        if_exp_q.push_back(exp);
        wait_done(1'b1, c0, exp_lat, name);
        tick();
        bus.in_if_req = 1'b0;
    endtask

    task automatic run_lsb(input vec_t v, input string name);
        int    c0;
        int    n;
        wr_t   w;
        lexp_t e;
        c0 = cyc;
        n  = (v.size == SIZE_BYTE) ? 1 : (v.size == SIZE_HALF) ? 2 : 4;
        bus.in_lsb_req   = 1'b1;
        bus.in_lsb_wr    = v.wr;
        bus.in_lsb_size  = v.size;
        bus.in_lsb_addr  = v.addr;
        bus.in_lsb_wdata = v.wdata;
        if (v.wr) begin
            for (int i = 0; i < n; i++) begin
                w.a = v.addr + 32'(i);
                w.d = v.wdata[8*i +: 8];
                wr_q.push_back(w);
            end
        end
        e.chk  = ~v.wr;
        e.data = v.rdata;
        lsb_exp_q.push_back(e);
        if (v.gap > 0) begin
            tick();
            rdy = 1'b0;
            repeat (v.gap) tick();
            rdy = 1'b1;
        end
        wait_done(1'b0, c0, v.lat, name);
        tick();
        bus.in_lsb_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0;
        vec_t v;

        vecs[0]  = '{1'b1, SIZE_WORD, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,          0, 5};
        vecs[1]  = '{1'b0, SIZE_WORD, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 6};
        vecs[2]  = '{1'b0, SIZE_BYTE, 32'h0000_0101, 32'h0,         32'h0000_00BE, 0, 3};
        vecs[3]  = '{1'b0, SIZE_HALF, 32'h0000_0102, 32'h0,         32'h0000_DEAD, 0, 4};
        vecs[4]  = '{1'b1, SIZE_HALF, 32'h0000_0200, 32'h1234_ABCD, 32'h0,          0, 3};
        vecs[5]  = '{1'b0, SIZE_WORD, 32'h0000_0200, 32'h0,         32'h0302_ABCD, 0, 6};
        vecs[6]  = '{1'b1, SIZE_BYTE, 32'h0000_0203, 32'hFFFF_FF77, 32'h0,          2, 4};
        vecs[7]  = '{1'b0, SIZE_WORD, 32'h0000_0200, 32'h0,         32'h7702_ABCD, 1, 7};
        vecs[8]  = '{1'b0, SIZE_WORD, 32'hFFFF_FFFE, 32'h0,         32'h0100_FFFE, 0, 6};
        vecs[9]  = '{1'b1, 2'd3,      32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0,          0, 5};
        vecs[10] = '{1'b0, SIZE_HALF, 32'h0000_0000, 32'h0,         32'h0000_FEF0, 0, 4};
        vecs[11] = '{1'b0, SIZE_BYTE, 32'hFFFF_FFFF, 32'h0,         32'h0000_000D, 0, 3};

        ram[32'h10] = 8'h13;
        ram[32'h11] = 8'h05;
        ram[32'h12] = 8'h00;
        ram[32'h13] = 8'h00;

        bus.in_flush       = 1'b0;
        bus.in_if_req      = 1'b0;
        bus.in_if_pc       = 32'h0;
        bus.in_lsb_req     = 1'b0;
        bus.in_lsb_wr      = 1'b0;
        bus.in_lsb_size    = 2'd0;
        bus.in_lsb_addr    = 32'h0;
        bus.in_lsb_wdata   = 32'h0;
        bus.io_buffer_full = 1'b0;

        tick();
        tick();
        @(negedge clk);
        check("reset mem_a", bus.mem_a, 32'h0);
        check("reset ctrl", {22'h0, bus.out_if_done, bus.out_lsb_done, bus.mem_wr, 1'b0, bus.mem_dout}, 32'h0);
        check("reset instr", bus.out_if_instr, 32'h0);
        check("reset rdata", bus.out_lsb_rdata, 32'h0);
        tick();
        rst = 1'b0;

        // Simultaneous requests after reset: fetch wins, then the load.
        v = '{1'b0, SIZE_BYTE, 32'h0000_0101, 32'h0, 32'h0000_0001, 0, 10};
        fork
            run_if(32'h10, 32'h0000_0513, 6, "collide1 fetch");
            run_lsb(v, "collide1 load");
        join
        // A repeat collision goes to the data port.
        v = '{1'b0, SIZE_BYTE, 32'h0000_0102, 32'h0, 32'h0000_0002, 0, 3};
        fork
            run_if(32'h10, 32'h0000_0513, 10, "collide2 fetch");
            run_lsb(v, "collide2 load");
        join

        // Single fetch, watching the address walk.
        c0 = cyc;
        bus.in_if_req = 1'b1;
        bus.in_if_pc  = 32'h10;
        if_exp_q.push_back(32'h0000_0513);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("fetch mem_a", bus.mem_a, 32'h10 + 32'(k));
        end
        wait_done(1'b1, c0, 6, "fetch");
        tick();
        bus.in_if_req = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_lsb(vecs[i], $sformatf("vec%0d", i));
        end

        // Flush in C3 of a fetch with a store waiting behind it.
        begin
            int    cnt0;
            int    cs;
            wr_t   w;
            lexp_t e;
            cnt0 = if_done_cnt;
            bus.in_if_req = 1'b1;
            bus.in_if_pc  = 32'h10;
            tick();
            tick();
            tick();
            bus.in_flush     = 1'b1;
            bus.in_if_req    = 1'b0;
            bus.in_lsb_req   = 1'b1;
            bus.in_lsb_wr    = 1'b1;
            bus.in_lsb_size  = SIZE_BYTE;
            bus.in_lsb_addr  = 32'h40;
            bus.in_lsb_wdata = 32'h5A;
            w.a = 32'h40;
            w.d = 8'h5A;
            wr_q.push_back(w);
            e.chk  = 1'b0;
            e.data = 32'h0;
            lsb_exp_q.push_back(e);
            cs = cyc;
            tick();
            bus.in_flush = 1'b0;
            @(negedge clk);
            check("flush state idle", 32'(dut.state_q), 32'(IDLE));
            check("flush mem_wr", 32'(bus.mem_wr), 32'h0);
            wait_done(1'b0, cs, 3, "flush store");
            tick();
            bus.in_lsb_req = 1'b0;
            repeat (8) tick();
            check("flush no if_done", 32'(if_done_cnt), 32'(cnt0));
        end

        // IO store stalled by a full buffer for three cycles.
        begin
            wr_t   w;
            lexp_t e;
            c0 = cyc;
            bus.in_lsb_req     = 1'b1;
            bus.in_lsb_wr      = 1'b1;
            bus.in_lsb_size    = SIZE_BYTE;
            bus.in_lsb_addr    = 32'h0003_0000;
            bus.in_lsb_wdata   = 32'h41;
            bus.io_buffer_full = 1'b1;
            w.a = 32'h0003_0000;
            w.d = 8'h41;
            wr_q.push_back(w);
            e.chk  = 1'b0;
            e.data = 32'h0;
            lsb_exp_q.push_back(e);
            for (int k = 1; k <= 3; k++) begin
                tick();
                @(negedge clk);
                check($sformatf("io stall wr c%0d", k), 32'(bus.mem_wr), 32'h0);
            end
            tick();
            bus.io_buffer_full = 1'b0;
            @(negedge clk);
            check("io resume wr", 32'(bus.mem_wr), 32'h1);
            wait_done(1'b0, c0, 5, "io store");
            tick();
            bus.in_lsb_req = 1'b0;
        end

        // Reset asserted while a fetch is in READ.
        begin
            int cnt0;
            cnt0 = if_done_cnt;
            bus.in_if_req = 1'b1;
            bus.in_if_pc  = 32'h20;
            tick();
            tick();
            tick();
            rst = 1'b1;
            #1;
            check("rst mem_a", bus.mem_a, 32'h0);
            check("rst ctrl", {22'h0, bus.out_if_done, bus.out_lsb_done, bus.mem_wr, 1'b0, bus.mem_dout}, 32'h0);
            check("rst instr", bus.out_if_instr, 32'h0);
            check("rst rdata", bus.out_lsb_rdata, 32'h0);
            check("rst state idle", 32'(dut.state_q), 32'(IDLE));
            bus.in_if_req = 1'b0;
            tick();
            rst = 1'b0;
            repeat (8) tick();
            check("rst no if_done", 32'(if_done_cnt), 32'(cnt0));
        end

        check("pending writes", 32'(wr_q.size()), 32'h0);
        check("pending fetches", 32'(if_exp_q.size()), 32'h0);
        check("pending lsb", 32'(lsb_exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
